// File: rtl/win_detector_if.sv
// Handshake and board bus between the Connect4 datapath/game FSM and the win detector.
interface win_detector_if;
    logic        start;
    logic [41:0] gameboard;
    logic [41:0] players_cells;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [41:0] win_mask;

    modport master (
        output start, gameboard, players_cells,
        input  busy, done, winner, win_mask
    );

    modport slave (
        input  start, gameboard, players_cells,
        output busy, done, winner, win_mask
    );
endinterface

// File: rtl/win_detector.sv
// Sequential four-in-a-row scanner: snapshots the 6x7 board on start, evaluates one
// anchor per cycle in all four directions, and reports winner/draw with a done pulse.
module win_detector (
    input  logic           clk,
    input  logic           reset,
    win_detector_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

    // Line templates anchored at cell 0; shifted by the anchor index.
    localparam logic [41:0] HMask  = 42'h000_0000_000F;
    localparam logic [41:0] VMask  = 42'h000_0020_4081;
    localparam logic [41:0] DrMask = 42'h000_0101_0101;
    localparam logic [41:0] DlMask = 42'h000_0004_1041;

    state_e      state_q, state_d;
    logic [5:0]  anchor_q, anchor_d;
    logic        found_q, found_d;
    logic [1:0]  player_q, player_d;
    logic [41:0] hit_mask_q, hit_mask_d;
    logic [41:0] board_q, board_d;
    logic [41:0] own_q, own_d;
    logic [1:0]  winner_q, winner_d;
    logic [41:0] win_mask_q, win_mask_d;

    logic [5:0]  row, col;
    logic        h_ok, v_ok, dr_ok, dl_ok;
    logic [41:0] m_h, m_v, m_dr, m_dl;
    logic        hit;
    logic [41:0] hit_mask;

    function automatic logic line_hit(input logic [41:0] occ, input logic [41:0] own,
                                      input logic [41:0] m);
        return ((occ & m) == m) && (((own & m) == m) || ((own & m) == '0));
    endfunction

    always_comb begin
        row   = anchor_q / 6'd7;
        col   = anchor_q % 6'd7;
        h_ok  = (col <= 6'd3);
        v_ok  = (row <= 6'd2);
        dr_ok = v_ok && (col <= 6'd3);
        dl_ok = v_ok && (col >= 6'd3);
        m_h   = HMask << anchor_q;
        m_v   = VMask << anchor_q;
        m_dr  = DrMask << anchor_q;
        m_dl  = DlMask << anchor_q;

        hit      = 1'b0;
        hit_mask = '0;
        if (h_ok && line_hit(board_q, own_q, m_h)) begin
            hit      = 1'b1;
            hit_mask = m_h;
        end else if (v_ok && line_hit(board_q, own_q, m_v)) begin
            hit      = 1'b1;
            hit_mask = m_v;
        end else if (dr_ok && line_hit(board_q, own_q, m_dr)) begin
            hit      = 1'b1;
            hit_mask = m_dr;
        end else if (dl_ok && line_hit(board_q, own_q, m_dl)) begin
            hit      = 1'b1;
            hit_mask = m_dl;
        end
    end

    always_comb begin
        state_d    = state_q;
        anchor_d   = anchor_q;
        found_d    = found_q;
        player_d   = player_q;
        hit_mask_d = hit_mask_q;
        board_d    = board_q;
        own_d      = own_q;
        winner_d   = winner_q;
        win_mask_d = win_mask_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    board_d  = bus.gameboard;
                    own_d    = bus.players_cells;
                    anchor_d = '0;
                    found_d  = 1'b0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                if (hit && !found_q) begin
                    found_d    = 1'b1;
                    hit_mask_d = hit_mask;
                    player_d   = (|(own_q & hit_mask)) ? 2'b10 : 2'b01;
                end
                if (anchor_q == 6'd41) begin
                    anchor_d = '0;
                    state_d  = StReport;
                    // Result registers load here so they are valid for the whole REPORT cycle.
                    if (found_d) begin
                        winner_d   = player_d;
                        win_mask_d = hit_mask_d;
                    end else begin
                        winner_d   = (&board_q) ? 2'b11 : 2'b00;
                        win_mask_d = '0;
                    end
                end else begin
                    anchor_d = anchor_q + 6'd1;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            anchor_q   <= '0;
            found_q    <= 1'b0;
            player_q   <= 2'b00;
            hit_mask_q <= '0;
            board_q    <= '0;
            own_q      <= '0;
            winner_q   <= 2'b00;
            win_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            anchor_q   <= anchor_d;
            found_q    <= found_d;
            player_q   <= player_d;
            hit_mask_q <= hit_mask_d;
            board_q    <= board_d;
            own_q      <= own_d;
            winner_q   <= winner_d;
            win_mask_q <= win_mask_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StReport);
    assign bus.winner   = winner_q;
    assign bus.win_mask = win_mask_q;
endmodule

// File: tb/tb_win_detector.sv
// Scoreboard bench for win_detector: stimulus pushes expected results, a negedge monitor
// pops and checks them whenever done is seen.
module tb_win_detector;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    win_detector_if bus ();

    win_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  winner;
        logic [41:0] mask;
        int unsigned start_cyc;
    } exp_t;

    localparam logic [41:0] VLine  = 42'h000_0020_4081;  // 0,7,14,21
    localparam logic [41:0] DrLine = 42'h000_0101_0101;  // 0,8,16,24
    localparam logic [41:0] DlLine = 42'h000_0104_1040;  // 6,12,18,24
    localparam logic [41:0] HTop3  = 42'h000_0000_0078;  // 3..6

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("winner", 64'(bus.winner), 64'(e.winner));
                chk("win_mask", 64'(bus.win_mask), 64'(e.mask));
                chk("latency", 64'(cyc - e.start_cyc), 64'd42);
                chk("busy_in_report", 64'(bus.busy), 64'd1);
            end
        end
    end

    task automatic run_scan(input logic [41:0] occ, input logic [41:0] own,
                            input logic [1:0] ew, input logic [41:0] em, input bit disturb);
        exp_t e;
        int   busy_cnt;
        @(negedge clk);
        bus.gameboard     = occ;
        bus.players_cells = own;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        e.winner    = ew;
        e.mask      = em;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        if (disturb) begin
            bus.gameboard     = '0;
            bus.players_cells = '1;
        end
        busy_cnt = 0;
        for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
            busy_cnt++;
            bus.start = (disturb && i == 10);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_cycles", 64'(busy_cnt), 64'd43);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [41:0] stripe_own();
        logic [41:0] v;
        v = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                v[r*7+c] = 1'(c & 1) ^ 1'((r >> 1) & 1);
        return v;
    endfunction

    initial begin
        logic [41:0] full;
        full              = '1;
        reset             = 1'b0;
        bus.start         = 1'b0;
        bus.gameboard     = '0;
        bus.players_cells = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_winner", 64'(bus.winner), 64'd0);
        chk("rst_mask", 64'(bus.win_mask), 64'd0);
        reset = 1'b1;

        run_scan('0, '0, 2'b00, '0, 1'b0);
        run_scan(VLine, '0, 2'b01, VLine, 1'b0);
        run_scan(DlLine, DlLine, 2'b10, DlLine, 1'b0);
        run_scan(DrLine, DrLine, 2'b10, DrLine, 1'b0);
        run_scan(full, stripe_own(), 2'b11, '0, 1'b0);
        run_scan(full & ~(42'd1 << 41), stripe_own(), 2'b00, '0, 1'b0);
        run_scan(HTop3 | VLine, HTop3, 2'b01, VLine, 1'b0);
        // Mixed ownership in the line; unoccupied cells all owned by player 2.
        run_scan(VLine, ~VLine | (42'd1 << 21), 2'b00, '0, 1'b0);
        // Inputs scrambled after capture plus a mid-scan start.
        run_scan(VLine, '0, 2'b01, VLine, 1'b1);

        // Abort a scan with reset sampled at E20.
        @(negedge clk);
        bus.gameboard     = HTop3;
        bus.players_cells = HTop3;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_winner", 64'(bus.winner), 64'd0);
        chk("abort_mask", 64'(bus.win_mask), 64'd0);
        reset = 1'b1;
        repeat (50) @(negedge clk);

        run_scan(HTop3, HTop3, 2'b10, HTop3, 1'b0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
